// File: rtl/pwm_capture_if.sv
// pwm_capture_if: line input and measurement results of the PWM capture block.
// The master side drives the PWM line and consumes results; the slave side is
// the capture block itself. CW must match the CW of the attached pwm_capture.
interface pwm_capture_if #(
    parameter int CW = 23
);
    logic          i_pwm;     // PWM line, asynchronous to the capture clock
    logic          o_valid;   // one-cycle strobe: o_high/o_period updated
    logic [CW-1:0] o_high;    // clocks high in the last frame
    logic [CW-1:0] o_period;  // clocks in the last frame, all-ones on timeout
    logic          o_stuck;   // level: no rising edge for 2^CW-1 clocks

    modport master (
        output i_pwm,
        input  o_valid,
        input  o_high,
        input  o_period,
        input  o_stuck
    );

    modport slave (
        input  i_pwm,
        output o_valid,
        output o_high,
        output o_period,
        output o_stuck
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (in i_clk cycles) of a PWM line.
// A frame runs from one synchronised rising edge to the next; each completed
// frame gives one o_valid strobe. A line without a rising edge long enough for
// the period counter to saturate produces a single timeout strobe and sets
// o_stuck until the next rising edge.
//
// Optional build macro: PWMCAP_DEGLITCH_EN
//   defined   - the synchronised line is filtered; it must hold a new level for
//               DG consecutive clocks before the filtered level follows.
//   undefined - every synchronised transition is an edge.
module pwm_capture #(
    parameter int CW = 23,
    parameter int DG = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    pwm_capture_if.slave cap
);

    // Counter constants: saturation value, the value one below it (the cycle on
    // which a timeout fires) and the frame-start value.
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = {{(CW-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    // Saturating increment: counters stick at all-ones and never wrap.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic s_last_q;
    logic s_pwm_s;
    logic rise_s;
    logic fall_s;

    // Two-flop synchroniser for the asynchronous line plus edge-detect history.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_last_q <= 1'b0;
        end else begin
            sync1_q  <= cap.i_pwm;
            sync2_q  <= sync1_q;
            s_last_q <= s_pwm_s;
        end
    end

`ifdef PWMCAP_DEGLITCH_EN
    localparam int             DCW        = (DG > 1) ? $clog2(DG) : 1;
    localparam logic [DCW-1:0] DCNT_LAST  = DCW'(DG - 1);
    localparam logic [DCW-1:0] DCNT_ONE   = DCW'(1'b1);
    localparam logic [DCW-1:0] DCNT_ZERO  = {DCW{1'b0}};

    logic           filt_q;
    logic           filt_d;
    logic [DCW-1:0] dcnt_q;
    logic [DCW-1:0] dcnt_d;

    // Filter: follow the synchronised line only after it has disagreed with the
    // filtered level for DG consecutive clocks; any agreement restarts the run.
    always_comb begin
        filt_d = filt_q;
        dcnt_d = DCNT_ZERO;
        if (sync2_q != filt_q) begin
            if (dcnt_q == DCNT_LAST) begin
                filt_d = sync2_q;
                dcnt_d = DCNT_ZERO;
            end else begin
                filt_d = filt_q;
                dcnt_d = dcnt_q + DCNT_ONE;
            end
        end else begin
            filt_d = filt_q;
            dcnt_d = DCNT_ZERO;
        end
    end

    // Filter level and disagreement run-length registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            filt_q <= 1'b0;
            dcnt_q <= DCNT_ZERO;
        end else begin
            filt_q <= filt_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign s_pwm_s = filt_q;
`else
    // DG only sizes the filter; it stays referenced in the unfiltered build.
    logic [31:0] dg_unused_s;
    assign dg_unused_s = 32'(DG);

    assign s_pwm_s = sync2_q;
`endif

    assign rise_s =  s_pwm_s & ~s_last_q;
    assign fall_s = ~s_pwm_s &  s_last_q;

    // ------------------------------------------------------------------
    // Frame FSM and counters
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] pcnt_q;
    logic [CW-1:0] pcnt_d;
    logic [CW-1:0] hcnt_q;
    logic [CW-1:0] hcnt_d;
    logic          timeout_s;

    // A timeout fires on the cycle the period counter would saturate; a rise on
    // that same cycle takes priority, which is why it is qualified later.
    assign timeout_s = (pcnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a rise always (re)starts a frame, otherwise a timeout
    // drops back to idle, otherwise the high/low phase follows the line.
    always_comb begin
        state_d = state_q;
        if (rise_s) begin
            state_d = S_HIGH;
        end else if (timeout_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_HIGH: begin
                    if (fall_s) begin
                        state_d = S_LOW;
                    end else begin
                        state_d = S_HIGH;
                    end
                end
                S_LOW:  state_d = S_LOW;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counter next values: a rise loads 1 into both (the rise cycle is the
    // first clock of the new frame); high time only grows while in S_HIGH
    // with the line still high, so it freezes from the falling-edge cycle.
    always_comb begin
        pcnt_d = sat_inc(pcnt_q);
        hcnt_d = hcnt_q;
        if (rise_s) begin
            pcnt_d = CNT_ONE;
            hcnt_d = CNT_ONE;
        end else if (timeout_s) begin
            pcnt_d = CNT_MAX;
            hcnt_d = hcnt_q;
        end else if ((state_q == S_HIGH) && s_pwm_s) begin
            pcnt_d = sat_inc(pcnt_q);
            hcnt_d = sat_inc(hcnt_q);
        end else begin
            pcnt_d = sat_inc(pcnt_q);
            hcnt_d = hcnt_q;
        end
    end

    // Period and high-time counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pcnt_q <= CNT_ZERO;
            hcnt_q <= CNT_ZERO;
        end else begin
            pcnt_q <= pcnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Result outputs
    // ------------------------------------------------------------------
    logic          valid_q;
    logic          valid_d;
    logic [CW-1:0] high_q;
    logic [CW-1:0] high_d;
    logic [CW-1:0] period_q;
    logic [CW-1:0] period_d;
    logic          stuck_q;
    logic          stuck_d;

    // Output decode: a rise in S_LOW closes a frame and publishes the counts;
    // a rise elsewhere only starts a frame; a timeout without a rise publishes
    // the saturated marker once (pcnt then sits at all-ones, so it cannot
    // re-fire). Results hold between strobes.
    always_comb begin
        valid_d  = 1'b0;
        high_d   = high_q;
        period_d = period_q;
        stuck_d  = stuck_q;
        if (rise_s) begin
            stuck_d = 1'b0;
            if (state_q == S_LOW) begin
                valid_d  = 1'b1;
                high_d   = hcnt_q;
                period_d = pcnt_q;
            end else begin
                valid_d  = 1'b0;
            end
        end else if (timeout_s) begin
            valid_d  = 1'b1;
            period_d = CNT_MAX;
            high_d   = s_pwm_s ? CNT_MAX : CNT_ZERO;
            stuck_d  = 1'b1;
        end else begin
            valid_d  = 1'b0;
        end
    end

    // Registered result outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q  <= 1'b0;
            high_q   <= CNT_ZERO;
            period_q <= CNT_ZERO;
            stuck_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            high_q   <= high_d;
            period_q <= period_d;
            stuck_q  <= stuck_d;
        end
    end

    assign cap.o_valid  = valid_q;
    assign cap.o_high   = high_q;
    assign cap.o_period = period_q;
    assign cap.o_stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture. Two instances are used:
// CW=8 for timeout/stuck and short-frame cases, CW=23 for the 64/192 waveform
// and glitch case. Expected results are queued when a frame-closing rise (or a
// timeout-producing level) is driven and compared when o_valid strobes.
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_capture_if #(.CW(8))  if8 ();
    pwm_capture_if #(.CW(23)) if23 ();

    pwm_capture #(.CW(8), .DG(4)) u_dut8 (
        .i_clk   (clk),
        .i_reset (rst),
        .cap     (if8)
    );

    pwm_capture #(.CW(23), .DG(4)) u_dut23 (
        .i_clk   (clk),
        .i_reset (rst),
        .cap     (if23)
    );

    typedef struct {
        int h;
        int p;
        int s;
    } exp_t;

    exp_t q8[$];
    exp_t q23[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cnt8   = 0;
    int   cnt23  = 0;
    int   push8  = 0;
    int   push23 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit big, input int eh, input int ep, input int es);
        exp_t e;
        e.h = eh;
        e.p = ep;
        e.s = es;
        if (big) begin
            q23.push_back(e);
            push23++;
        end else begin
            q8.push_back(e);
            push8++;
        end
    endtask

    // One pulse: rise, h cycles high, l cycles low. If push is set, the rise
    // closes the previous frame, whose result (eh, ep) is queued.
    task automatic pulse(input bit big, input int h, input int l,
                         input bit push, input int eh, input int ep);
        if (big) if23.i_pwm = 1'b1; else if8.i_pwm = 1'b1;
        if (push) push_exp(big, eh, ep, 0);
        repeat (h) @(negedge clk);
        if (big) if23.i_pwm = 1'b0; else if8.i_pwm = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    // Scoreboard for the CW=8 instance.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && if8.o_valid) begin
            cnt8++;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("high8",   32'(if8.o_high),   e.h);
                check("period8", 32'(if8.o_period), e.p);
                check("stuck8",  32'(if8.o_stuck),  e.s);
            end
        end
    end

    // Scoreboard for the CW=23 instance.
    always @(negedge clk) begin : mon23
        exp_t e;
        if (!rst && if23.o_valid) begin
            cnt23++;
            if (q23.size() > 0) begin
                e = q23.pop_front();
                check("high23",   32'(if23.o_high),   e.h);
                check("period23", 32'(if23.o_period), e.p);
                check("stuck23",  32'(if23.o_stuck),  e.s);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int last_h;
        int last_p;
        rst        = 1'b1;
        if8.i_pwm  = 1'b0;
        if23.i_pwm = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid8",   32'(if8.o_valid),   0);
        check("rst_high8",    32'(if8.o_high),    0);
        check("rst_period8",  32'(if8.o_period),  0);
        check("rst_stuck8",   32'(if8.o_stuck),   0);
        check("rst_valid23",  32'(if23.o_valid),  0);
        check("rst_period23", 32'(if23.o_period), 0);
        rst = 1'b0;

        // Line held low: one timeout strobe, then silence.
        push_exp(1'b0, 0, 255, 1);
        repeat (255 + 1000) @(negedge clk);
        check("strobes8_low_stuck", cnt8, push8);
        check("stuck8_low", 32'(if8.o_stuck), 1);

        // Line held high: rise clears stuck, then timeout with high all-ones.
        if8.i_pwm = 1'b1;
        push_exp(1'b0, 255, 255, 1);
        repeat (5) @(negedge clk);
        check("stuck8_rise_clear", 32'(if8.o_stuck), 0);
        repeat (300) @(negedge clk);
        check("strobes8_high_stuck", cnt8, push8);
        check("stuck8_high", 32'(if8.o_stuck), 1);

        // 10 low / 10 high: first rise clears stuck without a strobe.
        if8.i_pwm = 1'b0;
        repeat (10) @(negedge clk);
        if8.i_pwm = 1'b1;
        repeat (5) @(negedge clk);
        check("stuck8_clear", 32'(if8.o_stuck), 0);
        check("strobes8_restart", cnt8, push8);
        repeat (5) @(negedge clk);
        if8.i_pwm = 1'b0;
        repeat (10) @(negedge clk);
        pulse(1'b0, 10, 10, 1'b1, 10, 20);
        last_h = 10;
        last_p = 20;
`ifndef PWMCAP_DEGLITCH_EN
        // Narrowest waveform, then nearly-full duty.
        pulse(1'b0, 1, 1, 1'b1, 10, 20);
        repeat (4) pulse(1'b0, 1, 1, 1'b1, 1, 2);
        pulse(1'b0, 99, 1, 1'b1, 1, 2);
        repeat (2) pulse(1'b0, 99, 1, 1'b1, 99, 100);
        last_h = 99;
        last_p = 100;
`endif
        // Close the last frame, then leave the line low until it times out.
        if8.i_pwm = 1'b1;
        push_exp(1'b0, last_h, last_p, 0);
        repeat (10) @(negedge clk);
        if8.i_pwm = 1'b0;
        push_exp(1'b0, 0, 255, 1);
        repeat (300) @(negedge clk);
        check("strobes8_frames", cnt8, push8);
        check("q8_drained", q8.size(), 0);

        // CW=23: 64 high / 192 low x4 -> three strobes.
        pulse(1'b1, 64, 192, 1'b0, 0, 0);
        repeat (3) pulse(1'b1, 64, 192, 1'b1, 64, 256);
        check("strobes23_steady", cnt23, push23);
        check("stuck23", 32'(if23.o_stuck), 0);

        // Latency: strobe after the third clock edge following the rise.
        if23.i_pwm = 1'b1;
        push_exp(1'b1, 64, 256, 0);
`ifndef PWMCAP_DEGLITCH_EN
        @(posedge clk); #1;
        check("latency_edge1", 32'(if23.o_valid), 0);
        @(posedge clk); #1;
        check("latency_edge2", 32'(if23.o_valid), 0);
        @(posedge clk); #1;
        check("latency_edge3", 32'(if23.o_valid), 1);
        @(negedge clk);
        repeat (61) @(negedge clk);
`else
        repeat (64) @(negedge clk);
`endif
        if23.i_pwm = 1'b0;
        repeat (192) @(negedge clk);

        // 2-cycle low glitch inside the high phase.
        if23.i_pwm = 1'b1;
        push_exp(1'b1, 64, 256, 0);
        repeat (30) @(negedge clk);
        if23.i_pwm = 1'b0;
        repeat (2) @(negedge clk);
        if23.i_pwm = 1'b1;
`ifndef PWMCAP_DEGLITCH_EN
        push_exp(1'b1, 30, 32, 0);
`endif
        repeat (32) @(negedge clk);
        if23.i_pwm = 1'b0;
        repeat (192) @(negedge clk);
        if23.i_pwm = 1'b1;
`ifdef PWMCAP_DEGLITCH_EN
        push_exp(1'b1, 64, 256, 0);
`else
        push_exp(1'b1, 32, 224, 0);
`endif
        repeat (64) @(negedge clk);
        if23.i_pwm = 1'b0;
        repeat (20) @(negedge clk);
        check("strobes23_glitch", cnt23, push23);
        check("q23_drained", q23.size(), 0);

        // Asynchronous reset in the middle of a high phase.
        if8.i_pwm = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid8",   32'(if8.o_valid),   0);
        check("arst_high8",    32'(if8.o_high),    0);
        check("arst_period8",  32'(if8.o_period),  0);
        check("arst_stuck8",   32'(if8.o_stuck),   0);
        check("arst_high23",   32'(if23.o_high),   0);
        check("arst_period23", 32'(if23.o_period), 0);
        @(negedge clk);
        if8.i_pwm = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // After release: first rise starts a frame, second rise strobes.
        pulse(1'b0, 20, 20, 1'b0, 0, 0);
        check("strobes8_first_rise", cnt8, push8);
        pulse(1'b0, 20, 20, 1'b1, 20, 40);
        repeat (10) @(negedge clk);
        check("strobes8_after_reset", cnt8, push8);
        check("q8_after_reset", q8.size(), 0);
        check("strobes23_after_reset", cnt23, push23);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
